// File: rtl/iq_decim_accum.sv
`default_nettype none
// ============================================================================
//  Module      : iq_decim_accum
//  Description : Boxcar decimator for a multichannel IQ mixer. Sums each
//                channel's I and Q products over (dec_n+1) valid samples,
//                latches the sums into a shadow bank and serialises them as
//                I0,Q0,I1,Q1,... with a valid strobe and word index.
//                Optional macro IQ_DECIM_ROUND_EN: round-half-up with
//                positive saturation before truncation, plus one output
//                pipeline register.
//  Revision    : 1.0 - initial release
// ============================================================================
module iq_decim_accum #(
    parameter int NCHAN = 2,
    parameter int DW    = 20,
    parameter int CNTW  = 8,
    parameter int OUTW  = 28
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic [CNTW-1:0]              dec_n,
    input  logic                         iq_valid,
    input  logic [NCHAN*DW-1:0]          mixout_i,
    input  logic [NCHAN*DW-1:0]          mixout_q,
    output logic [OUTW-1:0]              dout,
    output logic                         dout_valid,
    output logic [$clog2(2*NCHAN)-1:0]   dout_idx,
    output logic                         overrun
);

    localparam int c_AW = DW + CNTW;
    localparam int c_NW = 2 * NCHAN;
    localparam int c_IW = $clog2(c_NW);
`ifdef IQ_DECIM_ROUND_EN
    // Keep one extra LSB below the output word: it is the rounding bit.
    localparam int c_SW = (c_AW > OUTW) ? OUTW + 1 : OUTW;
`else
    localparam int c_SW = OUTW;
`endif
    localparam logic [c_IW-1:0] c_LAST_IDX = c_IW'(c_NW - 1);

    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_SHIFT = 1'b1;

    logic signed [c_AW-1:0] w_in     [c_NW];
    logic signed [c_AW-1:0] w_sum    [c_NW];
    logic signed [c_AW-1:0] r_acc    [c_NW];
    logic        [c_SW-1:0] r_shadow [c_NW];

    logic [CNTW-1:0] r_count;
    logic [CNTW-1:0] r_period;
    logic [CNTW-1:0] w_period_eff;
    logic [0:0]      r_state;
    logic [c_IW-1:0] r_idx;
    logic            r_overrun;
    logic            w_take;
    logic            w_last;
    logic            w_busy;
    logic            w_final;
    logic            w_dump;
    logic            w_ovr;
    logic [c_SW-1:0] w_word;

    // Word order is I0,Q0,I1,Q1,...; inputs are sign-extended to the
    // accumulator width, which is wide enough that sums can never overflow.
    generate
        for (genvar k = 0; k < NCHAN; k++) begin : g_chan
            assign w_in[2*k]   = {{CNTW{mixout_i[(k+1)*DW-1]}}, mixout_i[k*DW +: DW]};
            assign w_in[2*k+1] = {{CNTW{mixout_q[(k+1)*DW-1]}}, mixout_q[k*DW +: DW]};
        end
        for (genvar w = 0; w < c_NW; w++) begin : g_sum
            assign w_sum[w] = r_acc[w] + w_in[w];
        end
    endgenerate

    // On the first sample of a period the live dec_n is the period length,
    // so dec_n=0 dumps that very sample.
    assign w_period_eff = (r_count == '0) ? dec_n : r_period;
    assign w_take       = enable & iq_valid;
    assign w_last       = w_take & (r_count == w_period_eff);
    assign w_busy       = (r_state == c_SHIFT);
    assign w_final      = w_busy & (r_idx == c_LAST_IDX);
    assign w_dump       = w_last & (~w_busy | w_final);
    assign w_ovr        = w_last & w_busy & ~w_final;

    // Sample counter and period capture; enable low parks the counter at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count  <= '0;
            r_period <= '0;
        end else if (!enable) begin
            r_count  <= '0;
        end else if (iq_valid) begin
            if (r_count == '0) begin
                r_period <= dec_n;
            end
            r_count <= w_last ? '0 : r_count + 1'b1;
        end
    end

    // Running sums; cleared at end of period and while disabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int w = 0; w < c_NW; w++) r_acc[w] <= '0;
        end else if (!enable || w_last) begin
            for (int w = 0; w < c_NW; w++) r_acc[w] <= '0;
        end else if (iq_valid) begin
            for (int w = 0; w < c_NW; w++) r_acc[w] <= w_sum[w];
        end
    end

    // Shadow bank: loaded only on an accepted dump (an overrun leaves it
    // intact). While disabled it is cleared once any in-flight word stream
    // has drained, so a serialisation already started always completes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int w = 0; w < c_NW; w++) r_shadow[w] <= '0;
        end else if (w_dump) begin
            for (int w = 0; w < c_NW; w++) r_shadow[w] <= w_sum[w][c_AW-1 -: c_SW];
        end else if (!enable && !w_busy) begin
            for (int w = 0; w < c_NW; w++) r_shadow[w] <= '0;
        end
    end

    // Serialiser FSM: a dump on the final-word cycle restarts at index 0
    // with no idle gap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
            r_idx   <= '0;
        end else if (w_dump) begin
            r_state <= c_SHIFT;
            r_idx   <= '0;
        end else if (w_busy) begin
            if (w_final) begin
                r_state <= c_IDLE;
                r_idx   <= '0;
            end else begin
                r_idx   <= r_idx + 1'b1;
            end
        end
    end

    // Sticky overrun flag; only reset clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overrun <= 1'b0;
        end else if (w_ovr) begin
            r_overrun <= 1'b1;
        end
    end

    assign w_word  = r_shadow[r_idx];
    assign overrun = r_overrun;

`ifdef IQ_DECIM_ROUND_EN
    logic [OUTW-1:0] w_scaled;
    logic [OUTW-1:0] r_dout;
    logic            r_dout_valid;
    logic [c_IW-1:0] r_dout_idx;

    // Adding half an output LSB then truncating equals adding the first
    // discarded bit to the truncated word; positive overflow saturates.
    generate
        if (c_AW > OUTW) begin : g_round
            logic [OUTW:0] w_rsum;
            assign w_rsum   = {w_word[OUTW], w_word[OUTW:1]} + {{OUTW{1'b0}}, w_word[0]};
            assign w_scaled = (w_rsum[OUTW] ^ w_rsum[OUTW-1]) ?
                              {1'b0, {(OUTW-1){1'b1}}} : w_rsum[OUTW-1:0];
        end else begin : g_pass
            assign w_scaled = w_word;
        end
    endgenerate

    // Output pipeline stage holding the rounded word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_dout_idx   <= '0;
        end else begin
            r_dout       <= w_busy ? w_scaled : '0;
            r_dout_valid <= w_busy;
            r_dout_idx   <= w_busy ? r_idx : '0;
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign dout_idx   = r_dout_idx;
`else
    assign dout       = w_busy ? w_word : '0;
    assign dout_valid = w_busy;
    assign dout_idx   = w_busy ? r_idx : '0;
`endif

endmodule
`default_nettype wire
